// File: rtl/hsk_pulse_dispatcher.sv
// Source-domain event dispatcher: counts local event pulses and issues them one at
// a time as single-cycle tvalid pulses, following the hsk_pulse_synchro tready handshake.
module hsk_pulse_dispatcher #(
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic             aclk,
    input  logic             arstn,
    input  logic             event_i,
    input  logic             clear_i,
    input  logic             tready_i,
    output logic             tvalid_o,
    output logic [CNT_W-1:0] pending_o,
    output logic             overflow_o,
    output logic             timeout_o
);

    localparam int unsigned TO_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
    logic              tvalid_nxt, overflow_nxt, timeout_nxt;
    logic              inc, dec, to_hit;

    always_comb begin
        state_nxt  = state;
        to_cnt_nxt = to_cnt;
        tvalid_nxt = 1'b0;
        dec        = 1'b0;
        to_hit     = 1'b0;

        case (state)
            IDLE: begin
                if (count != '0 && tready_i) begin
                    state_nxt  = ISSUE;
                    tvalid_nxt = 1'b1;
                    dec        = 1'b1;
                end
            end
            ISSUE: begin
                state_nxt  = WAIT_LOW;
                to_cnt_nxt = '0;
            end
            WAIT_LOW: begin
                if (!tready_i) begin
                    state_nxt = WAIT_HIGH;
                end else if (ACK_TIMEOUT > 0) begin
                    // Timed-out event counts as dispatched; it is not retried.
                    if (to_cnt == TO_LAST) begin
                        to_hit    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        to_cnt_nxt = to_cnt + 1'b1;
                    end
                end
            end
            WAIT_HIGH: begin
                if (tready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        inc          = event_i;
        count_nxt    = count;
        overflow_nxt = overflow_o & ~clear_i;
        if (inc && !dec) begin
            if (count == CNT_MAX) overflow_nxt = 1'b1;
            else                  count_nxt    = count + 1'b1;
        end else if (dec && !inc) begin
            count_nxt = count - 1'b1;
        end

        // A new timeout in the same cycle as clear_i leaves the flag set.
        timeout_nxt = to_hit | (timeout_o & ~clear_i);
    end

    always_ff @(posedge aclk) begin
        if (!arstn) begin
            state      <= IDLE;
            count      <= '0;
            to_cnt     <= '0;
            tvalid_o   <= 1'b0;
            overflow_o <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            to_cnt     <= to_cnt_nxt;
            tvalid_o   <= tvalid_nxt;
            overflow_o <= overflow_nxt;
            timeout_o  <= timeout_nxt;
        end
    end

    assign pending_o = count;

endmodule

// File: tb/tb_hsk_pulse_dispatcher.sv
// Scoreboard bench for hsk_pulse_dispatcher: instance a uses default parameters,
// instance b uses CNT_W=2, ACK_TIMEOUT=4 for saturation and timeout scenarios.
module tb_hsk_pulse_dispatcher;

    logic       aclk;
    logic       rst_a, ev_a, clr_a, tready_a, tvalid_a, ovf_a, to_a;
    logic [3:0] pend_a;
    logic       rst_b, ev_b, clr_b, tready_b, tvalid_b, ovf_b, to_b;
    logic [1:0] pend_b;
    logic       model_ready_a, model_ready_b, model_en_b, force_ready_b;

    int checks = 0;
    int errors = 0;
    int sb_a[$];
    int sb_b[$];
    int next_id_a = 0, next_id_b = 0;
    int pulse_cnt_a = 0, pulse_cnt_b = 0;
    int exp_cnt_b = 0;
    int peak_a = 0;
    logic prev_tv_a = 1'b0, prev_tv_b = 1'b0, saw_low_a = 1'b1;

    hsk_pulse_dispatcher #(.CNT_W(4), .ACK_TIMEOUT(16)) dut_a (
        .aclk(aclk), .arstn(rst_a), .event_i(ev_a), .clear_i(clr_a), .tready_i(tready_a),
        .tvalid_o(tvalid_a), .pending_o(pend_a), .overflow_o(ovf_a), .timeout_o(to_a)
    );

    hsk_pulse_dispatcher #(.CNT_W(2), .ACK_TIMEOUT(4)) dut_b (
        .aclk(aclk), .arstn(rst_b), .event_i(ev_b), .clear_i(clr_b), .tready_i(tready_b),
        .tvalid_o(tvalid_b), .pending_o(pend_b), .overflow_o(ovf_b), .timeout_o(to_b)
    );

    assign tready_a = model_ready_a;
    assign tready_b = model_en_b ? model_ready_b : force_ready_b;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Synchronizer stand-in: drop tready 2 cycles after a pulse, raise it 10 cycles later.
    initial begin
        model_ready_a = 1'b1;
        forever begin
            @(negedge aclk);
            if (tvalid_a) begin
                repeat (2) @(negedge aclk);
                model_ready_a = 1'b0;
                repeat (10) @(negedge aclk);
                model_ready_a = 1'b1;
            end
        end
    end

    initial begin
        model_ready_b = 1'b1;
        forever begin
            @(negedge aclk);
            if (model_en_b && tvalid_b) begin
                repeat (2) @(negedge aclk);
                model_ready_b = 1'b0;
                repeat (10) @(negedge aclk);
                model_ready_b = 1'b1;
            end
        end
    end

    always @(negedge aclk) begin
        int exp_id;
        if (!tready_a) saw_low_a = 1'b1;
        if (tvalid_a) begin
            check("a_no_back_to_back", 32'(prev_tv_a), 0);
            check("a_handshake_between_pulses", 32'(saw_low_a), 1);
            saw_low_a = 1'b0;
            if (sb_a.size() == 0) begin
                check("a_spurious_pulse", 1, 0);
            end else begin
                exp_id = sb_a.pop_front();
                check("a_pulse_order", pulse_cnt_a, exp_id);
            end
            pulse_cnt_a++;
        end
        prev_tv_a = tvalid_a;
        if (int'(pend_a) > peak_a) peak_a = int'(pend_a);
    end

    always @(negedge aclk) begin
        int exp_id;
        if (tvalid_b) begin
            check("b_no_back_to_back", 32'(prev_tv_b), 0);
            if (sb_b.size() == 0) begin
                check("b_spurious_pulse", 1, 0);
            end else begin
                exp_id = sb_b.pop_front();
                check("b_pulse_order", pulse_cnt_b, exp_id);
            end
            pulse_cnt_b++;
        end
        prev_tv_b = tvalid_b;
    end

    task automatic wait_pulses_a(input int target, input int budget);
        int n = 0;
        while (pulse_cnt_a < target && n < budget) begin
            @(negedge aclk);
            n++;
        end
        if (pulse_cnt_a < target) check("a_wait_pulses_budget", pulse_cnt_a, target);
    endtask

    task automatic wait_pulses_b(input int target, input int budget);
        int n = 0;
        while (pulse_cnt_b < target && n < budget) begin
            @(negedge aclk);
            n++;
        end
        if (pulse_cnt_b < target) check("b_wait_pulses_budget", pulse_cnt_b, target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        ev_a = 1'b0; ev_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        model_en_b = 1'b0; force_ready_b = 1'b1;

        // 1. reset with toggling events
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge aclk);
            ev_a = i[0]; ev_b = ~i[0];
            check("rst_a_outputs", {tvalid_a, pend_a, ovf_a, to_a}, 0);
            check("rst_b_outputs", {tvalid_b, pend_b, ovf_b, to_b}, 0);
        end
        @(negedge aclk);
        ev_a = 1'b0; ev_b = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge aclk);
        check("rel_a_outputs", {tvalid_a, pend_a, ovf_a, to_a}, 0);
        check("rel_b_outputs", {tvalid_b, pend_b, ovf_b, to_b}, 0);

        // 2. single event
        ev_a = 1'b1; sb_a.push_back(next_id_a++);
        @(negedge aclk);
        ev_a = 1'b0;
        check("single_pending_1", pend_a, 1);
        check("single_tvalid_early", tvalid_a, 0);
        @(negedge aclk);
        check("single_tvalid_high", tvalid_a, 1);
        check("single_pending_0", pend_a, 0);
        @(negedge aclk);
        check("single_tvalid_one_cycle", tvalid_a, 0);
        repeat (30) @(negedge aclk);
        check("single_pulse_count", pulse_cnt_a, 1);

        // 3. burst of five
        peak_a = 0;
        for (int unsigned i = 0; i < 5; i++) begin
            ev_a = 1'b1; sb_a.push_back(next_id_a++);
            @(negedge aclk);
        end
        ev_a = 1'b0;
        wait_pulses_a(6, 300);
        repeat (20) @(negedge aclk);
        check("burst_peak_4_or_5", 32'(peak_a == 4 || peak_a == 5), 1);
        check("burst_pulse_count", pulse_cnt_a, 6);
        check("burst_pending_0", pend_a, 0);
        check("burst_sb_empty", sb_a.size(), 0);
        check("burst_no_overflow", ovf_a, 0);

        // 5. event coinciding with dispatch
        ev_a = 1'b1; sb_a.push_back(next_id_a++);
        @(negedge aclk);
        sb_a.push_back(next_id_a++);
        @(negedge aclk);
        ev_a = 1'b0;
        check("simul_pending_stays_1", pend_a, 1);
        check("simul_tvalid", tvalid_a, 1);
        wait_pulses_a(8, 100);
        repeat (20) @(negedge aclk);
        check("simul_pulse_count", pulse_cnt_a, 8);
        check("simul_pending_0", pend_a, 0);
        check("simul_sb_empty", sb_a.size(), 0);
        check("a_timeout_never", to_a, 0);

        // 4. saturation with tready held low
        force_ready_b = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            ev_b = 1'b1;
            if (exp_cnt_b < 3) begin
                sb_b.push_back(next_id_b++);
                exp_cnt_b++;
            end
            @(negedge aclk);
        end
        ev_b = 1'b0;
        check("sat_pending_3", pend_b, 3);
        check("sat_overflow", ovf_b, 1);
        check("sat_no_pulse", pulse_cnt_b, 0);
        clr_b = 1'b1;
        @(negedge aclk);
        clr_b = 1'b0;
        check("sat_overflow_cleared", ovf_b, 0);
        check("sat_pending_kept", pend_b, 3);
        model_en_b = 1'b1;
        wait_pulses_b(3, 200);
        repeat (20) @(negedge aclk);
        check("sat_pulse_count", pulse_cnt_b, 3);
        check("sat_pending_0", pend_b, 0);
        check("sat_no_timeout", to_b, 0);
        check("sat_sb_empty", sb_b.size(), 0);

        // 6. timeout with tready stuck high
        force_ready_b = 1'b1;
        model_en_b = 1'b0;
        ev_b = 1'b1; sb_b.push_back(next_id_b++);
        @(negedge aclk);
        sb_b.push_back(next_id_b++);
        @(negedge aclk);
        ev_b = 1'b0;
        check("to1_tvalid", tvalid_b, 1);
        check("to1_pending_1", pend_b, 1);
        for (int unsigned k = 0; k < 4; k++) begin
            @(negedge aclk);
            check("to1_not_yet", to_b, 0);
        end
        @(negedge aclk);
        check("to1_timeout_set", to_b, 1);
        clr_b = 1'b1;
        @(negedge aclk);
        clr_b = 1'b0;
        check("to2_timeout_cleared", to_b, 0);
        check("to2_tvalid", tvalid_b, 1);
        check("to2_pending_0", pend_b, 0);
        for (int unsigned k = 0; k < 4; k++) begin
            @(negedge aclk);
            check("to2_not_yet", to_b, 0);
        end
        @(negedge aclk);
        check("to2_timeout_set", to_b, 1);
        repeat (10) @(negedge aclk);
        check("to_pulse_count", pulse_cnt_b, 5);
        check("to_pending_0", pend_b, 0);
        check("to_sb_empty", sb_b.size(), 0);
        rst_b = 1'b0;
        @(negedge aclk);
        rst_b = 1'b1;
        check("to_reset_clears", to_b, 0);
        @(negedge aclk);
        check("to_after_reset", to_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hsk_pulse_dispatcher.md
Name: hsk_pulse_dispatcher

Overview:
- Source-domain stage placed directly upstream of hsk_pulse_synchro.
- Accumulates single-cycle event pulses from local logic in a saturating counter.
- Issues them one at a time as single-cycle tvalid pulses into the synchronizer, honouring its tready handshake so that no event is lost while a crossing is in flight.
- Reports pending count, overflow and handshake timeout status.

Parameters:
- CNT_W, 4: width of the pending-event counter; saturates at 2^CNT_W-1.
- ACK_TIMEOUT, 16: max cycles in WAIT_LOW waiting for tready_i to drop after a pulse; 0 disables the timeout.

Ports:
- aclk  input  1  clock; all logic on rising edge.
- arstn  input  1  reset, synchronous, active-low.
- event_i  input  1  event strobe; each high cycle is one event.
- clear_i  input  1  clears sticky overflow_o and timeout_o.
- tready_i  input  1  ready from hsk_pulse_synchro; high = idle, able to accept a pulse.
- tvalid_o  output  1  single-cycle pulse to hsk_pulse_synchro tvalid_i.
- pending_o  output  CNT_W  events accepted but not yet dispatched.
- overflow_o  output  1  sticky; an event was dropped at saturation.
- timeout_o  output  1  sticky; tready_i failed to drop within ACK_TIMEOUT.

Behaviour:
- Reset, sampled at an aclk edge with arstn=0:
  - FSM goes to IDLE; counter, timeout counter, tvalid_o, overflow_o and timeout_o are cleared to 0.
  - A mid-operation reset discards pending events and any in-flight state.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: if count>0 and tready_i=1, go to ISSUE. On that edge, set tvalid_o=1 and decrement count.
  - ISSUE: lasts exactly 1 cycle with tvalid_o=1, then go to WAIT_LOW with tvalid_o=0.
  - WAIT_LOW: if tready_i=0, go to WAIT_HIGH. If ACK_TIMEOUT>0 and ACK_TIMEOUT cycles elapse with tready_i=1, set timeout_o and go to IDLE. The event is counted as dispatched and is not retried.
  - WAIT_HIGH: if tready_i=1, go to IDLE. No timeout applies here; the synchronizer handshake governs.
- Throughput: at most one pulse per IDLE→ISSUE→WAIT_LOW→WAIT_HIGH→IDLE loop. tvalid_o is never high on two consecutive cycles.
- Counter update per edge, with inc = event_i and dec = (IDLE→ISSUE transition):
  - inc and dec together: count unchanged.
  - inc only, count < max: count+1.
  - inc only, count = max: count unchanged, overflow_o set to 1.
  - dec only: count-1; never below 0, since dec requires count>0.
- pending_o equals the registered count.
- Latency:
  - event_i high at edge N gives count=1 after N.
  - If the FSM is in IDLE and tready_i=1, tvalid_o is high during the cycle following edge N+1.
- clear_i=1 clears both sticky flags at the next edge. A set condition in the same cycle wins, leaving the flag at 1.
- The timeout counter resets on entry to WAIT_LOW. It is CLOG2(ACK_TIMEOUT+1) bits wide, minimum 1.
- Outside IDLE, tready_i is ignored except by the WAIT_LOW and WAIT_HIGH rules.

Test Plan:
1. Reset: hold arstn=0 for 5 cycles with event_i toggling → tvalid_o=0, pending_o=0, overflow_o=0, timeout_o=0 throughout and on the first cycle after release.
2. Single event, tready_i=1, synchronizer model drops tready_i 2 cycles after the pulse and raises it 10 cycles later:
   - event_i high 1 cycle.
   - Required: tvalid_o high exactly 1 cycle, 2 edges after event_i.
   - Required: pending_o goes 1→0.
   - Required: no second pulse.
3. Burst of 5 consecutive event_i cycles with the same model → pending_o peaks at 4 or 5, exactly 5 tvalid_o pulses, each separated by a full tready low/high cycle, final pending_o=0.
4. Saturation, CNT_W=2, tready_i held 0:
   - Apply 5 events.
   - Required: pending_o=3 and overflow_o=1.
   - Then clear_i → overflow_o=0.
   - Then release tready_i → exactly 3 pulses.
5. Simultaneous event and dispatch: count=1 in IDLE, tready_i=1, event_i=1 on the dispatch edge → pending_o stays 1, tvalid_o pulses, and a second pulse follows after the handshake completes.
6. Timeout, ACK_TIMEOUT=4, tready_i stuck at 1:
   - Apply 2 events.
   - Required: each pulse is followed by timeout_o=1 set 4 cycles into WAIT_LOW.
   - Required: 2 pulses total, pending_o=0.
   - Required: an arstn pulse clears timeout_o.
